// File: rtl/alu_job_master.sv
// Bus master that runs one ALU job per start pulse: fetch A/B from RAM, program
// the ALU slave, poll its status, then copy the 64-bit result back to RAM.
module alu_job_master #(
  parameter logic [7:0]  ALU_OPA_ADDR  = 8'h80,
  parameter logic [7:0]  ALU_OPB_ADDR  = 8'h81,
  parameter logic [7:0]  ALU_OP_ADDR   = 8'h82,
  parameter logic [7:0]  ALU_GO_ADDR   = 8'h83,
  parameter logic [7:0]  ALU_STAT_ADDR = 8'h84,
  parameter logic [7:0]  ALU_RLO_ADDR  = 8'h85,
  parameter logic [7:0]  ALU_RHI_ADDR  = 8'h86,
  parameter int unsigned POLL_LIMIT    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op_code,
  input  logic [7:0]  src_addr,
  input  logic [7:0]  dst_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        M_req,
  output logic        M_wr,
  output logic [7:0]  M_addr,
  output logic [31:0] M_dout,
  input  logic        M_grant,
  input  logic [31:0] M_din
);

  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
  localparam logic [PW-1:0] LIMIT_M1 = PW'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_RD_A, S_RD_B, S_WR_A, S_WR_B, S_WR_OP, S_WR_GO,
    S_POLL, S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI, S_FIN
  } state_t;

  state_t        state_q;
  logic [3:0]    op_q;
  logic [7:0]    src_q;
  logic [7:0]    dst_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   lo_q;
  logic [31:0]   hi_q;
  logic [PW-1:0] poll_q;
  logic          ph_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          req_q;
  logic          wr_q;
  logic [7:0]    addr_q;
  logic [31:0]   dout_q;

  // Job sequencer; every bus output is set on the edge that enters the state using it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      src_q   <= 8'd0;
      dst_q   <= 8'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      poll_q  <= '0;
      ph_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 8'd0;
      dout_q  <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_code;
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            poll_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (M_grant) begin
            addr_q  <= src_q;
            wr_q    <= 1'b0;
            ph_q    <= 1'b0;
            state_q <= S_RD_A;
          end
        end
        // Two-cycle reads: ph_q=0 address cycle, ph_q=1 data cycle; grant loss restarts.
        S_RD_A, S_RD_B, S_POLL, S_RD_LO, S_RD_HI: begin
          if (!M_grant) begin
            ph_q <= 1'b0;
          end else if (!ph_q) begin
            ph_q <= 1'b1;
          end else begin
            ph_q <= 1'b0;
            case (state_q)
              S_RD_A: begin
                a_q     <= M_din;
                addr_q  <= src_q + 8'd1;
                state_q <= S_RD_B;
              end
              S_RD_B: begin
                b_q     <= M_din;
                addr_q  <= ALU_OPA_ADDR;
                dout_q  <= a_q;
                wr_q    <= 1'b1;
                state_q <= S_WR_A;
              end
              S_POLL: begin
                if (M_din[0]) begin
                  addr_q  <= ALU_RLO_ADDR;
                  state_q <= S_RD_LO;
                end else if (poll_q == LIMIT_M1) begin
                  poll_q  <= poll_q + 1'b1;
                  err_q   <= 1'b1;
                  req_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_FIN;
                end else begin
                  poll_q <= poll_q + 1'b1;
                end
              end
              S_RD_LO: begin
                lo_q    <= M_din;
                addr_q  <= ALU_RHI_ADDR;
                state_q <= S_RD_HI;
              end
              S_RD_HI: begin
                hi_q    <= M_din;
                addr_q  <= dst_q;
                dout_q  <= lo_q;
                wr_q    <= 1'b1;
                state_q <= S_WR_LO;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
        // Single-cycle writes complete only on a granted cycle.
        S_WR_A, S_WR_B, S_WR_OP, S_WR_GO, S_WR_LO, S_WR_HI: begin
          if (M_grant) begin
            case (state_q)
              S_WR_A: begin
                addr_q  <= ALU_OPB_ADDR;
                dout_q  <= b_q;
                state_q <= S_WR_B;
              end
              S_WR_B: begin
                addr_q  <= ALU_OP_ADDR;
                dout_q  <= {28'd0, op_q};
                state_q <= S_WR_OP;
              end
              S_WR_OP: begin
                addr_q  <= ALU_GO_ADDR;
                dout_q  <= 32'd1;
                state_q <= S_WR_GO;
              end
              S_WR_GO: begin
                addr_q  <= ALU_STAT_ADDR;
                wr_q    <= 1'b0;
                ph_q    <= 1'b0;
                state_q <= S_POLL;
              end
              S_WR_LO: begin
                addr_q  <= dst_q + 8'd1;
                dout_q  <= hi_q;
                state_q <= S_WR_HI;
              end
              S_WR_HI: begin
                wr_q    <= 1'b0;
                req_q   <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign M_req  = req_q;
  assign M_wr   = wr_q;
  assign M_addr = addr_q;
  assign M_dout = dout_q;

endmodule
